// File: rtl/tlul_socket_pkg.sv
// Shared TL-UL channel types, device address map and decode helper for the 1-to-N device socket.
package tlul_socket_pkg;

  localparam int MaxNumDev = 16;

  typedef logic [$clog2(MaxNumDev+1)-1:0] dev_idx_t;

  localparam logic [2:0] OpPutFull    = 3'h0;
  localparam logic [2:0] OpPutPartial = 3'h1;
  localparam logic [2:0] OpGet        = 3'h4;
  localparam logic [2:0] OpAccessAck  = 3'h0;
  localparam logic [2:0] OpAccessAckD = 3'h1;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] mask;
  } addr_map_t;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  // Lowest matching index wins; no match returns num_dev (the error responder slot).
  function automatic dev_idx_t decode(input logic [31:0] addr,
                                      input addr_map_t [MaxNumDev-1:0] map,
                                      input int unsigned num_dev);
    dev_idx_t idx;
    idx = dev_idx_t'(num_dev);
    for (int i = MaxNumDev - 1; i >= 0; i--) begin
      if ((i < int'(num_dev)) && ((addr & map[i].mask) == (map[i].base & map[i].mask))) begin
        idx = dev_idx_t'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/tlul_err_resp.sv
// One-entry responder that completes unmapped requests with d_error set.
module tlul_err_resp
  import tlul_socket_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_i,
  output tl_d2h_t tl_o
);

  logic       vld_q, vld_d;
  logic       is_get_q, is_get_d;
  logic [1:0] size_q, size_d;
  logic [7:0] src_q, src_d;
  logic       accept_s;
  logic       unused_tl_s;

  assign unused_tl_s = ^{tl_i.a_param, tl_i.a_address, tl_i.a_mask, tl_i.a_data, tl_i.a_user};

  // Capture on accept; a pending response blocks new requests even if d_ready is high.
  always_comb begin
    accept_s = tl_i.a_valid & ~vld_q;
    vld_d    = vld_q;
    is_get_d = is_get_q;
    size_d   = size_q;
    src_d    = src_q;
    if (accept_s) begin
      vld_d    = 1'b1;
      is_get_d = (tl_i.a_opcode == OpGet);
      size_d   = tl_i.a_size;
      src_d    = tl_i.a_source;
    end else if (vld_q && tl_i.d_ready) begin
      vld_d = 1'b0;
    end else begin
      vld_d = vld_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q    <= 1'b0;
      is_get_q <= 1'b0;
      size_q   <= 2'd0;
      src_q    <= 8'd0;
    end else begin
      vld_q    <= vld_d;
      is_get_q <= is_get_d;
      size_q   <= size_d;
      src_q    <= src_d;
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.a_ready  = ~vld_q;
    tl_o.d_valid  = vld_q;
    tl_o.d_opcode = is_get_q ? OpAccessAckD : OpAccessAck;
    tl_o.d_data   = is_get_q ? 32'hFFFF_FFFF : 32'h0000_0000;
    tl_o.d_size   = size_q;
    tl_o.d_source = src_q;
    tl_o.d_error  = 1'b1;
  end

endmodule

// File: rtl/tlul_dev_socket_1n.sv
// 1-to-N TL-UL device socket: address decode, single-target ordering, outstanding counter, D mux.
module tlul_dev_socket_1n
  import tlul_socket_pkg::*;
#(
  parameter int unsigned             NumDev   = 7,
  parameter int unsigned             MaxOutst = 4,
  parameter logic [NumDev-1:0][31:0] DevBase  = '0,
  parameter logic [NumDev-1:0][31:0] DevMask  = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  tl_h2d_t                tl_h_i,
  output tl_d2h_t                tl_h_o,
  output tl_h2d_t [NumDev-1:0]   tl_d_o,
  input  tl_d2h_t [NumDev-1:0]   tl_d_i
);

  localparam int unsigned     CntW   = $clog2(MaxOutst + 1);
  localparam dev_idx_t        ErrIdx = dev_idx_t'(NumDev);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutst);

  addr_map_t [MaxNumDev-1:0] map_s;
  dev_idx_t                  sel_s, tgt_q, tgt_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      busy_s, stall_s, dev_a_ready_s, a_ready_s, a_hs_s, d_hs_s;
  tl_h2d_t                   err_req_s;
  tl_d2h_t                   err_rsp_s, d_mux_s;

  for (genvar g = 0; g < MaxNumDev; g++) begin : g_map
    if (g < NumDev) begin : g_used
      assign map_s[g] = '{base: DevBase[g], mask: DevMask[g]};
    end else begin : g_pad
      assign map_s[g] = '0;
    end
  end

  // Decode and stall: only one target may have requests in flight at a time.
  always_comb begin
    sel_s         = decode(tl_h_i.a_address, map_s, NumDev);
    busy_s        = (cnt_q != '0);
    stall_s       = tl_h_i.a_valid & ((busy_s & (sel_s != tgt_q)) | (cnt_q == CntMax));
    dev_a_ready_s = 1'b0;
    for (int i = 0; i < int'(NumDev); i++) begin
      dev_a_ready_s = dev_a_ready_s | ((sel_s == dev_idx_t'(i)) & tl_d_i[i].a_ready);
    end
    a_ready_s = ~stall_s & ((sel_s == ErrIdx) ? err_rsp_s.a_ready : dev_a_ready_s);
    a_hs_s    = tl_h_i.a_valid & a_ready_s;
  end

  always_comb begin
    err_req_s         = tl_h_i;
    err_req_s.a_valid = tl_h_i.a_valid & (sel_s == ErrIdx) & ~stall_s;
    err_req_s.d_ready = tl_h_i.d_ready & busy_s & (tgt_q == ErrIdx);
    for (int i = 0; i < int'(NumDev); i++) begin
      tl_d_o[i]         = tl_h_i;
      tl_d_o[i].a_valid = tl_h_i.a_valid & (sel_s == dev_idx_t'(i)) & ~stall_s;
      tl_d_o[i].d_ready = tl_h_i.d_ready & busy_s & (tgt_q == dev_idx_t'(i));
    end
  end

  // Responses are only accepted from the current target while something is outstanding.
  always_comb begin
    d_mux_s = err_rsp_s;
    for (int i = 0; i < int'(NumDev); i++) begin
      d_mux_s = (tgt_q == dev_idx_t'(i)) ? tl_d_i[i] : d_mux_s;
    end
    tl_h_o         = d_mux_s;
    tl_h_o.d_valid = d_mux_s.d_valid & busy_s;
    tl_h_o.a_ready = a_ready_s;
    d_hs_s         = d_mux_s.d_valid & busy_s & tl_h_i.d_ready;
  end

  always_comb begin
    case ({a_hs_s, d_hs_s})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    tgt_d = a_hs_s ? sel_s : tgt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      tgt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      tgt_q <= tgt_d;
    end
  end

  tlul_err_resp u_err_resp (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tl_i   (err_req_s),
    .tl_o   (err_rsp_s)
  );

endmodule

// File: tb/tb_tlul_dev_socket_1n.sv
// Directed bench for tlul_dev_socket_1n: decode, error responder, full/ordering stalls and reset.
module tb_tlul_dev_socket_1n;
  import tlul_socket_pkg::*;

  localparam int unsigned NDEV = 3;
  localparam logic [NDEV-1:0][31:0] BASE = {32'h1000_0000, 32'h1000_1000, 32'h1000_0000};
  localparam logic [NDEV-1:0][31:0] MASK = {32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000};

  logic                clk = 1'b0;
  logic                rst_ni = 1'b0;
  tl_h2d_t             h_req;
  tl_d2h_t             h_rsp;
  tl_h2d_t [NDEV-1:0]  d_req;
  tl_d2h_t [NDEV-1:0]  d_rsp;
  logic [NDEV-1:0]     dev_av, dev_dr;
  int                  n_checks = 0;
  int                  n_errors = 0;

  assign dev_av = {d_req[2].a_valid, d_req[1].a_valid, d_req[0].a_valid};
  assign dev_dr = {d_req[2].d_ready, d_req[1].d_ready, d_req[0].d_ready};

  always #5 clk = ~clk;

  tlul_dev_socket_1n #(
    .NumDev   (NDEV),
    .MaxOutst (4),
    .DevBase  (BASE),
    .DevMask  (MASK)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .tl_h_i (h_req),
    .tl_h_o (h_rsp),
    .tl_d_o (d_req),
    .tl_d_i (d_rsp)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic [2:0] op, input logic [31:0] addr, input logic [7:0] src);
    h_req.a_valid   = v;
    h_req.a_opcode  = op;
    h_req.a_address = addr;
    h_req.a_source  = src;
    h_req.a_size    = 2'd2;
    h_req.a_mask    = 4'hF;
    h_req.a_user    = 16'h1234;
  endtask

  initial begin
    h_req = '0;
    d_rsp = '0;
    for (int i = 0; i < int'(NDEV); i++) d_rsp[i].a_ready = 1'b1;
    h_req.d_ready = 1'b1;
    #1;
    check_eq("rst_cnt", 32'(dut.cnt_q), 32'd0);
    check_eq("rst_dvalid", 32'(h_rsp.d_valid), 32'd0);
    check_eq("rst_dev_av", 32'(dev_av), 32'd0);
    check_eq("rst_dev_dr", 32'(dev_dr), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    cyc();

    // Decode priority: overlapping windows go to the lowest index.
    req(1'b1, OpGet, 32'h1000_0010, 8'd1);
    #1 check_eq("dec_overlap_dev0", 32'(dev_av), 32'b001);
    req(1'b1, OpGet, 32'h1000_5000, 8'd1);
    #1 check_eq("dec_dev2", 32'(dev_av), 32'b100);
    req(1'b0, OpGet, 32'h0, 8'd0);
    cyc();

    // Test 1: Get to dev1, response returned.
    req(1'b1, OpGet, 32'h1000_1004, 8'd3);
    #1;
    check_eq("t1_dev_av", 32'(dev_av), 32'b010);
    check_eq("t1_a_user", 32'(d_req[1].a_user), 32'h1234);
    check_eq("t1_a_ready", 32'(h_rsp.a_ready), 32'd1);
    cyc();
    req(1'b0, OpGet, 32'h0, 8'd0);
    check_eq("t1_cnt1", 32'(dut.cnt_q), 32'd1);
    d_rsp[1].d_valid  = 1'b1;
    d_rsp[1].d_opcode = OpAccessAckD;
    d_rsp[1].d_data   = 32'hCAFE_F00D;
    d_rsp[1].d_source = 8'd3;
    d_rsp[1].d_user   = 16'h5A5A;
    #1;
    check_eq("t1_dvalid", 32'(h_rsp.d_valid), 32'd1);
    check_eq("t1_ddata", h_rsp.d_data, 32'hCAFE_F00D);
    check_eq("t1_duser", 32'(h_rsp.d_user), 32'h5A5A);
    check_eq("t1_dev_dr", 32'(dev_dr), 32'b010);
    cyc();
    d_rsp[1].d_valid = 1'b0;
    check_eq("t1_cnt0", 32'(dut.cnt_q), 32'd0);

    // Test 2: unmapped Get and Put complete through the error responder.
    h_req.d_ready = 1'b0;
    req(1'b1, OpGet, 32'h2000_0000, 8'd5);
    #1;
    check_eq("t2_a_ready", 32'(h_rsp.a_ready), 32'd1);
    check_eq("t2_dev_av", 32'(dev_av), 32'd0);
    cyc();
    req(1'b0, OpGet, 32'h0, 8'd0);
    #1;
    check_eq("t2_dvalid", 32'(h_rsp.d_valid), 32'd1);
    check_eq("t2_derror", 32'(h_rsp.d_error), 32'd1);
    check_eq("t2_dopcode", 32'(h_rsp.d_opcode), 32'(OpAccessAckD));
    check_eq("t2_ddata", h_rsp.d_data, 32'hFFFF_FFFF);
    check_eq("t2_dsource", 32'(h_rsp.d_source), 32'd5);
    check_eq("t2_dsize", 32'(h_rsp.d_size), 32'd2);
    check_eq("t2_duser", 32'(h_rsp.d_user), 32'd0);
    cyc();
    check_eq("t2_hold", 32'(h_rsp.d_valid), 32'd1);
    req(1'b1, OpPutFull, 32'h2000_0000, 8'd6);
    h_req.d_ready = 1'b1;
    #1 check_eq("t2_busy_block", 32'(h_rsp.a_ready), 32'd0);
    cyc();
    check_eq("t2_put_ready", 32'(h_rsp.a_ready), 32'd1);
    cyc();
    req(1'b0, OpGet, 32'h0, 8'd0);
    #1;
    check_eq("t2_put_dvalid", 32'(h_rsp.d_valid), 32'd1);
    check_eq("t2_put_dopcode", 32'(h_rsp.d_opcode), 32'(OpAccessAck));
    check_eq("t2_put_derror", 32'(h_rsp.d_error), 32'd1);
    check_eq("t2_put_dsource", 32'(h_rsp.d_source), 32'd6);
    cyc();
    check_eq("t2_cnt0", 32'(dut.cnt_q), 32'd0);

    // Test 3: outstanding limit of 4, strict full.
    req(1'b1, OpGet, 32'h1000_0000, 8'd7);
    for (int k = 0; k < 6; k++) begin
      #1 check_eq($sformatf("t3_a_ready_%0d", k), 32'(h_rsp.a_ready), (k < 4) ? 32'd1 : 32'd0);
      cyc();
    end
    check_eq("t3_cnt4", 32'(dut.cnt_q), 32'd4);
    d_rsp[0].d_valid  = 1'b1;
    d_rsp[0].d_opcode = OpAccessAckD;
    d_rsp[0].d_data   = 32'h0;
    #1;
    check_eq("t3_full_strict", 32'(h_rsp.a_ready), 32'd0);
    check_eq("t3_dvalid", 32'(h_rsp.d_valid), 32'd1);
    cyc();
    check_eq("t3_cnt3", 32'(dut.cnt_q), 32'd3);
    d_rsp[0].d_valid = 1'b0;
    #1 check_eq("t3_reopen", 32'(h_rsp.a_ready), 32'd1);
    cyc();
    check_eq("t3_cnt4b", 32'(dut.cnt_q), 32'd4);
    req(1'b0, OpGet, 32'h0, 8'd0);
    d_rsp[0].d_valid = 1'b1;
    repeat (4) cyc();
    d_rsp[0].d_valid = 1'b0;
    check_eq("t3_drain", 32'(dut.cnt_q), 32'd0);

    // Test 4: switching target waits for the previous one; spurious dev1 response ignored.
    req(1'b1, OpGet, 32'h1000_0000, 8'd8);
    cyc();
    req(1'b1, OpGet, 32'h1000_1000, 8'd9);
    d_rsp[1].d_valid = 1'b1;
    d_rsp[1].d_data  = 32'hBAD0_BAD0;
    #1;
    check_eq("t4_a_ready", 32'(h_rsp.a_ready), 32'd0);
    check_eq("t4_dev_av", 32'(dev_av), 32'd0);
    check_eq("t4_spur_dvalid", 32'(h_rsp.d_valid), 32'd0);
    check_eq("t4_spur_dr", 32'(dev_dr), 32'b001);
    cyc();
    d_rsp[0].d_valid = 1'b1;
    d_rsp[0].d_data  = 32'h1111_2222;
    #1;
    check_eq("t4_ddata", h_rsp.d_data, 32'h1111_2222);
    check_eq("t4_a_ready_hold", 32'(h_rsp.a_ready), 32'd0);
    cyc();
    d_rsp[0].d_valid = 1'b0;
    d_rsp[1].d_valid = 1'b0;
    #1;
    check_eq("t4_a_ready_go", 32'(h_rsp.a_ready), 32'd1);
    check_eq("t4_dev_av_go", 32'(dev_av), 32'b010);
    cyc();
    req(1'b0, OpGet, 32'h0, 8'd0);
    check_eq("t4_cnt1", 32'(dut.cnt_q), 32'd1);
    d_rsp[1].d_valid = 1'b1;
    d_rsp[1].d_data  = 32'h3333_4444;
    #1 check_eq("t4_dev1_data", h_rsp.d_data, 32'h3333_4444);
    cyc();
    d_rsp[1].d_valid = 1'b0;
    check_eq("t4_cnt0", 32'(dut.cnt_q), 32'd0);

    // Test 5: simultaneous A and D handshakes, then reset with requests in flight.
    req(1'b1, OpGet, 32'h1000_0000, 8'd10);
    cyc();
    cyc();
    check_eq("t5_cnt2", 32'(dut.cnt_q), 32'd2);
    d_rsp[0].d_valid = 1'b1;
    #1;
    check_eq("t5_both_a", 32'(h_rsp.a_ready), 32'd1);
    check_eq("t5_both_d", 32'(h_rsp.d_valid), 32'd1);
    cyc();
    check_eq("t5_cnt_same", 32'(dut.cnt_q), 32'd2);
    d_rsp[0].d_valid = 1'b0;
    cyc();
    check_eq("t5_cnt3", 32'(dut.cnt_q), 32'd3);
    req(1'b0, OpGet, 32'h0, 8'd0);
    d_rsp[0].d_valid = 1'b1;
    rst_ni = 1'b0;
    #1;
    check_eq("t5_rst_cnt", 32'(dut.cnt_q), 32'd0);
    check_eq("t5_rst_dvalid", 32'(h_rsp.d_valid), 32'd0);
    check_eq("t5_rst_dev_av", 32'(dev_av), 32'd0);
    check_eq("t5_rst_dev_dr", 32'(dev_dr), 32'd0);
    cyc();
    rst_ni = 1'b1;
    d_rsp[0].d_valid = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
